// File: rtl/interrupt_service_unit.sv
// rtl/interrupt_service_unit.sv - interrupt entry/return sequencer with PC redirect and flag save/restore
module interrupt_service_unit #(
  parameter int DIR_WIDTH  = 10,
  parameter int FLAG_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_interruption,
  input  logic [DIR_WIDTH-1:0]  dir_in,
  input  logic [DIR_WIDTH-1:0]  pc_current,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  input  logic                  reti,
  input  logic                  cpu_stall,
  output logic                  pc_load,
  output logic [DIR_WIDTH-1:0]  pc_load_dir,
  output logic                  flags_restore,
  output logic [FLAG_WIDTH-1:0] flags_out,
  output logic                  s_finished,
  output logic                  in_service,
  output logic                  err_reti,
  output logic [3:0]            dropped_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2,
    ST_EXIT    = 2'd3
  } state_t;

  state_t                state_q;
  logic                  s_int_q;
  logic                  seen_low_q;
  logic                  pending_q;
  logic [DIR_WIDTH-1:0]  ret_addr_q;
  logic [DIR_WIDTH-1:0]  pc_load_dir_q;
  logic [FLAG_WIDTH-1:0] saved_flags_q;
  logic                  pc_load_q;
  logic                  flags_restore_q;
  logic                  s_finished_q;
  logic                  in_service_q;
  logic                  err_reti_q;
  logic [3:0]            dropped_q;
  logic [3:0]            dropped_d;

  logic req_event;
  logic drop_now;
  logic take_entry;

  // A request only counts once the line has been seen low since reset, so a
  // level already high when reset releases is not mistaken for a new edge.
  assign req_event  = s_interruption & ~s_int_q & seen_low_q;
  assign drop_now   = req_event & ((state_q == ST_ENTER) | (state_q == ST_SERVICE));
  assign take_entry = (state_q == ST_IDLE) & (req_event | pending_q) & ~cpu_stall;

  // Saturating count of requests that arrive while already servicing
  always_comb begin
    dropped_d = dropped_q;
    if (drop_now && (dropped_q != 4'hF)) begin
      dropped_d = dropped_q + 4'd1;
    end
  end

  // Request line history for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_int_q    <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      s_int_q <= s_interruption;
      if (!s_interruption) begin
        seen_low_q <= 1'b1;
      end
    end
  end

  // Drop counter and sticky illegal-return flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropped_q  <= 4'd0;
      err_reti_q <= 1'b0;
    end else begin
      dropped_q <= dropped_d;
      if (reti && (state_q != ST_SERVICE)) begin
        err_reti_q <= 1'b1;
      end
    end
  end

  // Service sequencer; outputs are registered alongside the state so they
  // line up exactly with the ENTER and EXIT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      pending_q       <= 1'b0;
      ret_addr_q      <= '0;
      saved_flags_q   <= '0;
      pc_load_q       <= 1'b0;
      pc_load_dir_q   <= '0;
      flags_restore_q <= 1'b0;
      s_finished_q    <= 1'b0;
      in_service_q    <= 1'b0;
    end else begin
      pc_load_q       <= 1'b0;
      pc_load_dir_q   <= '0;
      flags_restore_q <= 1'b0;
      s_finished_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take_entry) begin
            // The vector lives only in pc_load_dir_q: it is needed for the
            // single ENTER cycle and nowhere else.
            state_q       <= ST_ENTER;
            pending_q     <= 1'b0;
            ret_addr_q    <= pc_current;
            saved_flags_q <= flags_in;
            pc_load_q     <= 1'b1;
            pc_load_dir_q <= dir_in;
            in_service_q  <= 1'b1;
          end else if (req_event) begin
            pending_q <= 1'b1;
          end
        end
        ST_ENTER: begin
          state_q <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (reti) begin
            state_q         <= ST_EXIT;
            pc_load_q       <= 1'b1;
            pc_load_dir_q   <= ret_addr_q;
            flags_restore_q <= 1'b1;
            s_finished_q    <= 1'b1;
            in_service_q    <= 1'b0;
          end
        end
        ST_EXIT: begin
          state_q <= ST_IDLE;
          if (req_event) begin
            pending_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_load       = pc_load_q;
  assign pc_load_dir   = pc_load_dir_q;
  assign flags_restore = flags_restore_q;
  assign flags_out     = saved_flags_q;
  assign s_finished    = s_finished_q;
  assign in_service    = in_service_q;
  assign err_reti      = err_reti_q;
  assign dropped_cnt   = dropped_q;

endmodule

// File: doc/interrupt_service_unit.md
INTERRUPT_SERVICE_UNIT -- requirements
Module: interrupt_service_unit

Interface
REQ-001 Parameter DIR_WIDTH, default 10, SHALL set the subroutine/return address width.
REQ-002 Parameter FLAG_WIDTH, default 2, SHALL set the saved status-flag width (Z, C).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-low (0 = reset).
REQ-005 s_interruption  input  1  SHALL be the request from the interrupt controller.
REQ-006 dir_in  input  DIR_WIDTH  SHALL carry the subroutine address for the current request.
REQ-007 pc_current  input  DIR_WIDTH  SHALL carry the address of the next instruction to execute.
REQ-008 flags_in  input  FLAG_WIDTH  SHALL carry the live CPU status flags.
REQ-009 reti  input  1  SHALL be the decoded return-from-interrupt strobe.
REQ-010 cpu_stall  input  1  SHALL, when high, forbid PC redirection for entry.
REQ-011 pc_load  output  1  SHALL request the PC to load pc_load_dir this cycle.
REQ-012 pc_load_dir  output  DIR_WIDTH  SHALL carry the vector or return address.
REQ-013 flags_restore  output  1  SHALL request the CPU to load flags_out this cycle.
REQ-014 flags_out  output  FLAG_WIDTH  SHALL carry the saved flags.
REQ-015 s_finished  output  1  SHALL be a one-cycle pulse telling the controller service is complete.
REQ-016 in_service  output  1  SHALL be high in states ENTER and SERVICE.
REQ-017 err_reti  output  1  SHALL be a sticky flag for an illegal reti.
REQ-018 dropped_cnt  output  4  SHALL count discarded requests, saturating.

Function
REQ-019 States SHALL be IDLE, ENTER, SERVICE, EXIT; encoding free.
REQ-020 A request event SHALL be a rising edge of s_interruption, detected against a registered copy of its previous value.
REQ-021 A request event SHALL set an internal pending bit in IDLE or EXIT.
REQ-022 IDLE -> ENTER SHALL occur on the first rising edge where (event or pending) and cpu_stall=0; pending is cleared on that edge.
REQ-023 On the IDLE->ENTER edge, the unit SHALL capture dir_in as vector, pc_current as ret_addr, and flags_in as saved_flags.
REQ-024 In ENTER (exactly one cycle), the unit SHALL drive pc_load=1 and pc_load_dir=vector; ENTER -> SERVICE unconditionally.
REQ-025 SERVICE -> EXIT SHALL occur on an edge with reti=1.
REQ-026 In EXIT (exactly one cycle), the unit SHALL drive pc_load=1, pc_load_dir=ret_addr, flags_restore=1, flags_out=saved_flags, s_finished=1; EXIT -> IDLE unconditionally.
REQ-027 Outside ENTER/EXIT, pc_load, flags_restore and s_finished SHALL be 0, and pc_load_dir SHALL be 0.
REQ-028 flags_out SHALL hold saved_flags at all times.
REQ-029 Entry latency SHALL be one cycle: with the event sampled at edge N, pc_load is high between edges N and N+1.
REQ-030 A request event in ENTER or SERVICE, including the cycle reti is sampled, SHALL be discarded and SHALL increment dropped_cnt, saturating at 15.
REQ-031 reti sampled in IDLE, ENTER or EXIT SHALL be ignored for state and SHALL set err_reti until reset.
REQ-032 cpu_stall SHALL NOT delay exit; EXIT occurs regardless of cpu_stall.
REQ-033 A request event during cpu_stall in IDLE SHALL be held pending, not dropped.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, and SHALL clear pending, the edge-detect register, vector, ret_addr, saved_flags, err_reti and dropped_cnt to 0.
REQ-035 During reset, all outputs SHALL be 0.
REQ-036 Reset asserted in any state, including mid-ENTER or mid-EXIT, SHALL abort without a further s_finished pulse.
REQ-037 After reset deasserts with s_interruption already high, no event SHALL occur until s_interruption falls and rises again.

Verification
REQ-038 Basic entry: with dir_in=10'h3FB, pc_current=10'h012, flags_in=2'b10, raise s_interruption -> next cycle pc_load=1, pc_load_dir=10'h3FB, in_service=1.
REQ-039 Basic return: continuing REQ-038, pulse reti -> next cycle pc_load=1, pc_load_dir=10'h012, flags_restore=1, flags_out=2'b10, s_finished=1 for one cycle, then IDLE.
REQ-040 Stalled entry: raise s_interruption with cpu_stall=1 for 3 cycles, then drop cpu_stall -> pc_load asserts in the cycle after cpu_stall falls, with no drop counted.
REQ-041 Drops: issue 17 request events during SERVICE -> dropped_cnt=15, state remains SERVICE.
REQ-042 Illegal reti: pulse reti in IDLE -> err_reti=1 and stays set, no pc_load; then reset=0 -> err_reti=0.
REQ-043 Back-to-back: give a request event during EXIT -> s_finished pulses, then ENTER follows at the next edge with the new dir_in.
